mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default `ADDR_WIDTH (8), address width.
REQ-002 Parameter DATA_WIDTH, default `DATA_WIDTH (8), data width.
REQ-003 Parameter WAIT_CYCLES, default 2, range 0..15, wait states per access when MEMCTRL_WAIT_EN is defined.
REQ-004 clk  in  1  single clock; all state changes on posedge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 req  in  1  access request; sampled only while ready=1.
REQ-007 we  in  1  1=write, 0=read; sampled with req.
REQ-008 addr_in  in  ADDR_WIDTH  access address; sampled with req.
REQ-009 wdata  in  DATA_WIDTH  write data; sampled with req.
REQ-010 ready  out  1  high only in IDLE; request may be accepted.
REQ-011 done  out  1  one-cycle pulse on access completion.
REQ-012 rdata  out  DATA_WIDTH  last read result; holds until the next read completes.
REQ-013 mem_rw  out  1  to memory rw; 1=read/memory drives bus, 0=write.
REQ-014 mem_memio  out  1  to memory memio; enables the memory operation at the posedge.
REQ-015 mem_addr  out  ADDR_WIDTH  to memory addr.
REQ-016 mem_data  inout  DATA_WIDTH  shared data bus; driven by mem_ctrl only when its output enable is set, else high-Z.

Function
REQ-017 Accept: at a posedge with state IDLE and req=1, mem_ctrl SHALL latch we, addr_in and wdata, and leave IDLE; req in any other state is ignored, with no queueing.
REQ-018 States: IDLE, RD_ISSUE, RD_WAIT, RD_CAPT, WR_TURN, WR_COMMIT, WR_WAIT, DONE.
REQ-019 mem_addr SHALL equal the latched address in every non-IDLE state; it holds its last value in IDLE.
REQ-020 Read path: IDLE -> RD_ISSUE (mem_memio=1, mem_rw=1) -> RD_WAIT (WAIT_CYCLES cycles, memio=0, rw=1; skipped if 0) -> RD_CAPT (memio=0, rw=1; rdata <= mem_data at exit edge) -> DONE.
REQ-021 Write path: IDLE -> WR_TURN (rw=0, memio=0, output enable off: bus turnaround) -> WR_COMMIT (rw=0, memio=1, drive wdata) -> WR_WAIT (WAIT_CYCLES cycles, rw=0, memio=0, drive wdata; skipped if 0) -> DONE.
REQ-022 mem_ctrl SHALL drive mem_data only in WR_COMMIT and WR_WAIT; in every state with mem_rw=1 it SHALL be high-Z.
REQ-023 DONE SHALL last exactly one cycle with done=1, memio=0, rw=1, then return to IDLE.
REQ-024 Latency with zero wait states: done SHALL be high in the 3rd cycle after the accept edge for both reads and writes; each wait state adds one cycle.
REQ-025 Throughput: req held high SHALL yield one access per 4+WAIT_CYCLES cycles, because IDLE is always re-entered for one cycle.
REQ-026 A wait counter of 4 bits SHALL count WAIT_CYCLES-1 down to 0; WAIT_CYCLES=0 SHALL skip the wait state with no extra cycle.

Reset
REQ-027 With rst=1 at a posedge, in any state including mid-access, mem_ctrl SHALL enter IDLE with ready=1, done=0, rdata=0, mem_rw=1, mem_memio=0, mem_addr=0, output enable off and wait counter=0.
REQ-028 A write interrupted by reset before WR_COMMIT SHALL issue no memio pulse; an interrupted read SHALL leave rdata=0.

Configuration
REQ-029 Macro MEMCTRL_WAIT_EN: when defined, RD_WAIT, WR_WAIT and the wait counter SHALL be compiled in and honour WAIT_CYCLES.
REQ-030 When MEMCTRL_WAIT_EN is not defined, those states and the counter SHALL be absent, WAIT_CYCLES SHALL be ignored, and latency SHALL be fixed at zero wait states.

Verification
REQ-031 Setup: the bench memory model is preloaded with [1]=0x50, [2]=0x09, macro off; read addr 0x01 -> done in cycle 3, rdata=0x50, exactly one memio pulse with rw=1.
REQ-032 Write 0xA5 to 0x10, then read 0x10 -> rdata=0xA5; during the write mem_data is high-Z in WR_TURN and 0xA5 in WR_COMMIT.
REQ-033 Macro on, WAIT_CYCLES=2: read 0x02 -> done in cycle 5, rdata=0x09; WAIT_CYCLES=0 -> done in cycle 3.
REQ-034 Hold req=1 for 12 cycles on reads of 0x01 (macro off) -> exactly 3 done pulses, ready low except in IDLE.
REQ-035 Assert rst in WR_TURN of a write of 0xFF to 0x01 -> IDLE next cycle, no memio pulse, a later read of 0x01 returns 0x50.
REQ-036 Every cycle -> assert no bus contention: mem_data is never driven by mem_ctrl while mem_rw=1.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences single read/write accesses to a shared-bus memory.
// The memory is addressed with mem_addr and strobed with mem_memio. A read
// samples the shared mem_data bus one cycle after the strobe. A write leaves
// the bus undriven for one turnaround cycle before the controller drives it.
// Optional feature macro: MEMCTRL_WAIT_EN. When it is defined, the RD_WAIT
// and WR_WAIT states and a 4-bit wait counter insert WAIT_CYCLES extra
// cycles per access. When it is undefined, accesses always run with zero
// wait states and WAIT_CYCLES is ignored.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module mem_ctrl #(
  parameter int ADDR_WIDTH  = `ADDR_WIDTH,
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_rw,
  output logic                  mem_memio,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_range
    $error("mem_ctrl: WAIT_CYCLES must lie in 0..15");
  end

`ifdef MEMCTRL_WAIT_EN
  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, RD_CAPT, WR_TURN, WR_COMMIT, WR_WAIT, DONE
  } state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [3:0] wait_cnt;
`else
  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_CAPT, WR_TURN, WR_COMMIT, DONE
  } state_t;
`endif

  state_t                state;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  drive_en;

  assign mem_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

  // Access sequencer: every output is registered alongside the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      rdata     <= '0;
      mem_rw    <= 1'b1;
      mem_memio <= 1'b0;
      mem_addr  <= '0;
      drive_en  <= 1'b0;
      wdata_q   <= '0;
`ifdef MEMCTRL_WAIT_EN
      wait_cnt  <= 4'd0;
`endif
    end else begin
      done      <= 1'b0;
      mem_memio <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            wdata_q  <= wdata;
            mem_addr <= addr_in;
            ready    <= 1'b0;
            if (we) begin
              state    <= WR_TURN;
              mem_rw   <= 1'b0;
              drive_en <= 1'b0;
            end else begin
              state     <= RD_ISSUE;
              mem_rw    <= 1'b1;
              mem_memio <= 1'b1;
            end
          end
        end
        RD_ISSUE: begin
`ifdef MEMCTRL_WAIT_EN
          if (WAIT_CYCLES != 0) begin
            state    <= RD_WAIT;
            wait_cnt <= WAIT_LOAD;
          end else begin
            state <= RD_CAPT;
          end
`else
          state <= RD_CAPT;
`endif
        end
`ifdef MEMCTRL_WAIT_EN
        RD_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= RD_CAPT;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
`endif
        RD_CAPT: begin
          rdata <= mem_data;
          state <= DONE;
          done  <= 1'b1;
        end
        WR_TURN: begin
          state     <= WR_COMMIT;
          mem_memio <= 1'b1;
          drive_en  <= 1'b1;
        end
        WR_COMMIT: begin
`ifdef MEMCTRL_WAIT_EN
          if (WAIT_CYCLES != 0) begin
            state    <= WR_WAIT;
            wait_cnt <= WAIT_LOAD;
          end else begin
            state    <= DONE;
            drive_en <= 1'b0;
            mem_rw   <= 1'b1;
            done     <= 1'b1;
          end
`else
          state    <= DONE;
          drive_en <= 1'b0;
          mem_rw   <= 1'b1;
          done     <= 1'b1;
`endif
        end
`ifdef MEMCTRL_WAIT_EN
        WR_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state    <= DONE;
            drive_en <= 1'b0;
            mem_rw   <= 1'b1;
            done     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
`endif
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          ready    <= 1'b1;
          mem_rw   <= 1'b1;
          drive_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
